irrigation_ctrl: RTL
====================

IRRIGATION_CTRL -- requirements
Module: irrigation_ctrl

Interface
REQ-001 Parameter DEAD_CYCLES, default 3, break-before-make gap in cycles between two irrigation valves; legal range 1..255.
REQ-002 Parameter FILL_TIMEOUT, default 1000, maximum cycles v_fill may stay open; legal range 1..65535; used only with IRRIG_FILL_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 pulse  in  1  one-cycle event from the upstream level-to-pulse stage; requests re-evaluation.
REQ-006 h, m, l  in  1 each  high, mid and low water-level sensors.
REQ-007 As  in  1  sprinkler request level.
REQ-008 Gt  in  1  drip request level.
REQ-009 v_sprinkler, v_drip, v_fill  out  1 each  registered valve drives.
REQ-010 alarm  out  1  registered fault indication.
REQ-011 state  out  3  current FSM state code.

Function
REQ-012 The level decode of {h,m,l} SHALL be: 000 EMPTY, 001 LOW, 011 MID, 111 HIGH, all other codes INVALID.
REQ-013 The FSM states SHALL be IDLE=0, DEAD=1, SPRINKLE=2, DRIP=3, ERROR=4.
REQ-014 The target SHALL be: INVALID -> ERROR; else As=1 and level >= MID -> SPRINKLE; else Gt=1 and level >= LOW -> DRIP; else IDLE.
REQ-015 Inputs SHALL be sampled only on edges where pulse=1; with pulse=0 the state and valves SHALL hold, except for the DEAD countdown and the fill timeout.
REQ-016 On a pulse whose target equals the current state, the state SHALL stay unchanged.
REQ-017 On a pulse with a target of IDLE or ERROR, the FSM SHALL go directly to that target on the sampling edge.
REQ-018 On a pulse with a target of SPRINKLE or DRIP that differs from the current state, the FSM SHALL enter DEAD, clear both irrigation valves at that edge, and latch the target.
REQ-019 DEAD SHALL last exactly DEAD_CYCLES cycles; the latched target valve SHALL be seen high DEAD_CYCLES+1 edges after the sampling edge.
REQ-020 A pulse during DEAD SHALL re-evaluate the target and reload the counter, with IDLE or ERROR taking effect immediately.
REQ-021 v_sprinkler SHALL equal (state==SPRINKLE) and v_drip SHALL equal (state==DRIP); the two SHALL never be high together.
REQ-022 v_fill SHALL set on a pulse with level EMPTY or LOW, clear on a pulse with HIGH, hold on MID, and be forced to 0 in ERROR.
REQ-023 alarm SHALL equal (state==ERROR).
REQ-024 ERROR SHALL be left only on a pulse with a valid level, following REQ-017 and REQ-018.

Reset
REQ-025 With rstn low: state=IDLE, all valves 0, alarm 0, counters 0, latched target IDLE, asynchronously.
REQ-026 Reset mid-DEAD or mid-fill SHALL abort the operation; after release, outputs SHALL be unchanged until the first pulse.

Configuration
REQ-027 With IRRIG_FILL_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles with v_fill=1 and clear when v_fill=0.
REQ-028 With IRRIG_FILL_TIMEOUT_EN defined, the counter reaching FILL_TIMEOUT SHALL force ERROR and v_fill=0 on the next edge.
REQ-029 Without IRRIG_FILL_TIMEOUT_EN, the counter SHALL be absent and v_fill may stay open indefinitely.

Structure
REQ-030 Package irrigation_pkg SHALL hold the state encoding, the level encoding and the level-decode function.
REQ-031 A sub-module cycle_timer (loadable down-counter with a done flag) SHALL implement the DEAD countdown and be reused for the fill timeout.

Verification
REQ-032 Reset, then pulse with hml=011, As=1 -> DEAD for 3 cycles, v_sprinkler=1 on the 4th edge, v_fill=0.
REQ-033 In SPRINKLE, pulse with As=0, Gt=1, hml=001 -> v_sprinkler=0 next edge, v_drip=1 exactly 4 edges after the pulse, v_fill=1.
REQ-034 Pulse with hml=101 -> ERROR, alarm=1, all valves 0; then pulse with hml=111, Gt=1 -> DEAD, then DRIP, alarm=0.
REQ-035 Pulse during DEAD cycle 2 with As=Gt=0 -> IDLE next edge, no valve ever asserted.
REQ-036 IRRIG_FILL_TIMEOUT_EN with FILL_TIMEOUT=10, pulse with hml=000 and no further pulse -> v_fill high 10 cycles, then ERROR, alarm=1; without the macro, v_fill stays high.
REQ-037 Assert rstn low during DEAD -> all outputs 0 immediately; after release, no valve asserts without a pulse.

Source files
------------

// File: rtl/irrigation_pkg.sv
// Shared encodings for the irrigation controller: FSM states, water levels,
// the {h,m,l} level decode and the irrigation target selection.
package irrigation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEAD     = 3'd1,
    ST_SPRINKLE = 3'd2,
    ST_DRIP     = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  // Ordered so that valid levels compare numerically (EMPTY < LOW < MID < HIGH).
  typedef enum logic [2:0] {
    LVL_EMPTY   = 3'd0,
    LVL_LOW     = 3'd1,
    LVL_MID     = 3'd2,
    LVL_HIGH    = 3'd3,
    LVL_INVALID = 3'd7
  } level_e;

  function automatic level_e decode_level(input logic h, input logic m, input logic l);
    case ({h, m, l})
      3'b000:  return LVL_EMPTY;
      3'b001:  return LVL_LOW;
      3'b011:  return LVL_MID;
      3'b111:  return LVL_HIGH;
      default: return LVL_INVALID;
    endcase
  endfunction

  function automatic state_e pick_target(input level_e lvl, input logic as_req,
                                         input logic gt_req);
    if (lvl == LVL_INVALID)              return ST_ERROR;
    else if (as_req && lvl >= LVL_MID)   return ST_SPRINKLE;
    else if (gt_req && lvl >= LVL_LOW)   return ST_DRIP;
    else                                 return ST_IDLE;
  endfunction

endpackage

// File: rtl/irrigation_ctrl_cycle_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load)                 count_d = load_val;
    else if (count_q != '0)   count_d = count_q - WIDTH'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/irrigation_ctrl.sv
// Irrigation valve controller with break-before-make gap between sprinkler and drip.
// Optional fill-valve timeout is built when IRRIG_FILL_TIMEOUT_EN is defined.
module irrigation_ctrl
  import irrigation_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES  = 3,
  parameter int unsigned FILL_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       pulse,
  input  logic       h,
  input  logic       m,
  input  logic       l,
  input  logic       As,
  input  logic       Gt,
  output logic       v_sprinkler,
  output logic       v_drip,
  output logic       v_fill,
  output logic       alarm,
  output logic [2:0] state
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES > 255) begin : g_dead_range
    $error("DEAD_CYCLES must be within 1..255");
  end
  if (FILL_TIMEOUT < 1 || FILL_TIMEOUT > 65535) begin : g_fill_range
    $error("FILL_TIMEOUT must be within 1..65535");
  end

  state_e state_q, state_d;
  state_e target_q, target_d;
  logic   v_sprinkler_q, v_drip_q, v_fill_q, v_fill_d, alarm_q;
  level_e level;
  state_e target;
  logic   dead_load, dead_done, fill_expired;

  // The count is loaded at the sampling edge and runs down to zero; the move
  // to the latched target happens on the edge that sees zero, DEAD_CYCLES+1
  // edges after sampling.
  cycle_timer #(.WIDTH(8)) u_dead_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (dead_load),
    .load_val (8'(DEAD_CYCLES)),
    .done     (dead_done)
  );

`ifdef IRRIG_FILL_TIMEOUT_EN
  logic fill_done;

  // Held at FILL_TIMEOUT-1 while the valve is shut so that it expires after
  // exactly FILL_TIMEOUT cycles of v_fill=1.
  cycle_timer #(.WIDTH(16)) u_fill_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (!v_fill_q),
    .load_val (16'(FILL_TIMEOUT - 1)),
    .done     (fill_done)
  );

  assign fill_expired = v_fill_q && fill_done;
`else
  assign fill_expired = 1'b0;
`endif

  always_comb begin
    level     = decode_level(h, m, l);
    target    = pick_target(level, As, Gt);
    state_d   = state_q;
    target_d  = target_q;
    v_fill_d  = v_fill_q;
    dead_load = 1'b0;

    if (pulse) begin
      if (target == ST_IDLE || target == ST_ERROR) begin
        state_d = target;
      end else if (target != state_q) begin
        state_d   = ST_DEAD;
        target_d  = target;
        dead_load = 1'b1;
      end
      case (level)
        LVL_EMPTY, LVL_LOW: v_fill_d = 1'b1;
        LVL_HIGH:           v_fill_d = 1'b0;
        default:            v_fill_d = v_fill_q;
      endcase
    end else if (state_q == ST_DEAD && dead_done) begin
      state_d = target_q;
    end

    if (fill_expired)         state_d  = ST_ERROR;
    if (state_d == ST_ERROR)  v_fill_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      target_q      <= ST_IDLE;
      v_sprinkler_q <= 1'b0;
      v_drip_q      <= 1'b0;
      v_fill_q      <= 1'b0;
      alarm_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      v_sprinkler_q <= (state_d == ST_SPRINKLE);
      v_drip_q      <= (state_d == ST_DRIP);
      v_fill_q      <= v_fill_d;
      alarm_q       <= (state_d == ST_ERROR);
    end
  end

  assign state       = state_q;
  assign v_sprinkler = v_sprinkler_q;
  assign v_drip      = v_drip_q;
  assign v_fill      = v_fill_q;
  assign alarm       = alarm_q;

endmodule
